baud_os_gen: RTL

//  Next-generation UART baud timing source; supersedes the fixed-rate baud_pulse_gen.

---
 rtl/baud_pkg.sv | 22 ++
 rtl/baud_os_gen_frac_tick_div.sv | 118 +++++++++++
 rtl/baud_os_gen.sv | 81 ++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared UART timing constants and the default divisor helper.
package baud_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned FRAC_W_DEF     = 4;
    localparam int unsigned DIV_W_DEF      = 16;

    // Rounded clocks-per-os_tick in 1/2^frac_w units, i.e. {int, frac}.
    function automatic logic [63:0] DEFAULT_DIV(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned os,
        input int unsigned     frac_w
    );
        longint unsigned num;
        longint unsigned den;
        num = clk_hz << frac_w;
        den = baud * os;
        return 64'((num + (den / 2)) / den);
    endfunction

endpackage

// File: rtl/baud_os_gen_frac_tick_div.sv
// Fractional clock divider: owns cnt/acc, the divisor registers and cfg checks.
module frac_tick_div
    import baud_pkg::*;
#(
    parameter int unsigned           DIV_W    = DIV_W_DEF,
    parameter int unsigned           FRAC_W   = FRAC_W_DEF,
    parameter logic [DIV_W-1:0]      DEF_INT  = DIV_W'(13),
    parameter logic [FRAC_W-1:0]     DEF_FRAC = FRAC_W'(9)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    input  logic              cfg_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick_c,
    output logic              os_tick,
    output logic              cfg_err
);

    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned SUM_W = FRAC_W + 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_vld_q, pend_vld_d;
    logic              os_tick_q, os_tick_d;
    logic              cfg_err_q, cfg_err_d;

    logic [SUM_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  cur_len;
    logic              end_c;
    logic              cfg_ok;
    logic              boundary;

    // Period length, counter advance and divisor hand-over.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_vld_d  = pend_vld_q;
        os_tick_d   = 1'b0;
        tick_c      = 1'b0;

        acc_sum   = SUM_W'(acc_q) + SUM_W'(act_frac_q);
        cur_len   = CNT_W'(act_int_q) + CNT_W'(acc_sum[FRAC_W]);
        end_c     = (cnt_q == (cur_len - CNT_W'(1)));
        cfg_ok    = cfg_load && (div_int >= DIV_W'(2));
        cfg_err_d = cfg_load && !cfg_ok;

        if (!en || restart) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (end_c) begin
            cnt_d     = '0;
            acc_d     = acc_sum[FRAC_W-1:0];
            os_tick_d = 1'b1;
            tick_c    = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A new divisor takes effect only where a fresh period begins.
        boundary = !en || restart || tick_c;
        if (cfg_ok) begin
            if (boundary) begin
                act_int_d  = div_int;
                act_frac_d = div_frac;
                pend_vld_d = 1'b0;
            end else begin
                pend_int_d  = div_int;
                pend_frac_d = div_frac;
                pend_vld_d  = 1'b1;
            end
        end else if (pend_vld_q && boundary) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
            pend_vld_d = 1'b0;
        end
    end

    // State registers with synchronous reset to the default divisor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            act_int_q   <= DEF_INT;
            act_frac_q  <= DEF_FRAC;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_vld_q  <= 1'b0;
            os_tick_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_vld_q  <= pend_vld_d;
            os_tick_q   <= os_tick_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign os_tick = os_tick_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: rtl/baud_os_gen.sv
// UART baud timing source: oversample tick plus bit-centre and bit-end pulses.
module baud_os_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 25_000_000,
    parameter int unsigned DEFAULT_BAUD = 115200,
    parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int unsigned DIV_W        = DIV_W_DEF,
    parameter int unsigned FRAC_W       = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    input  logic              cfg_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_pulse,
    output logic              baud_pulse,
    output logic              cfg_err
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam logic [63:0] DEF_SCALED =
        DEFAULT_DIV(64'(CLK_FREQ), 64'(DEFAULT_BAUD), 64'(OVERSAMPLE), FRAC_W);
    localparam logic [DIV_W-1:0]  DEF_INT  = DEF_SCALED[FRAC_W +: DIV_W];
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_SCALED[FRAC_W-1:0];

    logic            tick_c;
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic            mid_q, mid_d;
    logic            baud_q, baud_d;

    frac_tick_div #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .DEF_INT  (DEF_INT),
        .DEF_FRAC (DEF_FRAC)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .restart  (restart),
        .cfg_load (cfg_load),
        .div_int  (div_int),
        .div_frac (div_frac),
        .tick_c   (tick_c),
        .os_tick  (os_tick),
        .cfg_err  (cfg_err)
    );

    // Oversample phase counter and centre/end decode, aligned with os_tick.
    always_comb begin
        os_cnt_d = os_cnt_q;
        mid_d    = tick_c && (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
        baud_d   = tick_c && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
        if (!en || restart) begin
            os_cnt_d = '0;
        end else if (tick_c) begin
            os_cnt_d = (os_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + OS_W'(1);
        end
    end

    // Phase and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            os_cnt_q <= '0;
            mid_q    <= 1'b0;
            baud_q   <= 1'b0;
        end else begin
            os_cnt_q <= os_cnt_d;
            mid_q    <= mid_d;
            baud_q   <= baud_d;
        end
    end

    assign mid_pulse  = mid_q;
    assign baud_pulse = baud_q;

endmodule
